// File: rtl/pipelined_barrel_shifter_if.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter_if
//
// Purpose: groups the upstream (in_*) and downstream (out_*) handshake buses of
// the pipelined barrel shifter, plus its busy status flag.
//
// Parameters:
//   NBits  data width (power of two, >= 4)
//   TAG_W  width of the sideband tag carried with every operation
//
// Signals:
//   in_valid  / in_ready   upstream handshake
//   in_data   [NBits]      operand to shift
//   in_shamt  [SHAMT_W]    shift amount 0..NBits-1
//   in_op     [2]          00 SLL, 01 SRL, 10 SRA, 11 ROTL
//   in_tag    [TAG_W]      sideband tag, passed through unchanged
//   out_valid / out_ready  downstream handshake
//   out_data  [NBits]      shifted result
//   out_tag   [TAG_W]      tag of the operation that produced out_data
//   busy                   any pipeline stage holds a valid operation
//
// Modports:
//   slave  - the shifter itself
//   master - the environment driving operations and consuming results
// -----------------------------------------------------------------------------
interface pipelined_barrel_shifter_if #(
    parameter int NBits = 32,
    parameter int TAG_W = 5
);
    localparam int SHAMT_W = $clog2(NBits);

    logic               in_valid;
    logic               in_ready;
    logic [NBits-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [NBits-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Purpose: log2(NBits)-stage pipelined barrel shifter supporting SLL, SRL, SRA
// and ROTL. Stage k conditionally shifts by 2^(SHAMT_W-1-k), so the most
// significant shift-amount bit is applied first. The whole pipeline advances
// as one unit whenever the output register is empty or being drained, giving
// one operation per cycle and a fixed latency of SHAMT_W cycles.
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset; flushes every stage
//   bus    pipelined_barrel_shifter_if.slave (in_*, out_*, busy)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int NBits = 32,
    parameter int TAG_W = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    pipelined_barrel_shifter_if.slave     bus
);
    localparam int SHAMT_W = $clog2(NBits);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    // Global advance: every stage moves forward together, or all hold.
    logic adv;

    // Per-stage register outputs, gathered so the next stage can read them.
    logic [SHAMT_W-1:0] stage_valid;
    logic [NBits-1:0]   stage_data  [SHAMT_W];
    logic [SHAMT_W-1:0] stage_shamt [SHAMT_W];
    op_e                stage_op    [SHAMT_W];
    logic [TAG_W-1:0]   stage_tag   [SHAMT_W];

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int BIT = SHAMT_W - 1 - gi;
            localparam int SH  = 1 << BIT;

            logic               src_valid;
            logic [NBits-1:0]   src_data;
            logic [SHAMT_W-1:0] src_shamt;
            op_e                src_op;
            logic [TAG_W-1:0]   src_tag;
            logic [NBits-1:0]   shifted;

            logic               valid_q, valid_d;
            logic [NBits-1:0]   data_q,  data_d;
            logic [SHAMT_W-1:0] shamt_q, shamt_d;
            op_e                op_q,    op_d;
            logic [TAG_W-1:0]   tag_q,   tag_d;

            if (gi == 0) begin : g_head
                // A cycle without an accepted operation loads a bubble.
                assign src_valid = bus.in_valid && bus.in_ready;
                assign src_data  = bus.in_data;
                assign src_shamt = bus.in_shamt;
                assign src_op    = op_e'(bus.in_op);
                assign src_tag   = bus.in_tag;
            end else begin : g_body
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[gi-1];
                assign src_shamt = stage_shamt[gi-1];
                assign src_op    = stage_op[gi-1];
                assign src_tag   = stage_tag[gi-1];
            end

            // Fixed-distance shift selected by this stage's shift-amount bit.
            always_comb begin
                shifted = src_data;
                if (src_shamt[BIT]) begin
                    case (src_op)
                        OP_SLL:  shifted = {src_data[NBits-1-SH:0], {SH{1'b0}}};
                        OP_SRL:  shifted = {{SH{1'b0}}, src_data[NBits-1:SH]};
                        OP_SRA:  shifted = {{SH{src_data[NBits-1]}}, src_data[NBits-1:SH]};
                        OP_ROTL: shifted = {src_data[NBits-1-SH:0], src_data[NBits-1:NBits-SH]};
                        default: shifted = src_data;
                    endcase
                end
            end

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                shamt_d = shamt_q;
                op_d    = op_q;
                tag_d   = tag_q;
                if (adv) begin
                    valid_d = src_valid;
                    data_d  = shifted;
                    shamt_d = src_shamt;
                    op_d    = src_op;
                    tag_d   = src_tag;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    shamt_q <= '0;
                    op_q    <= OP_SLL;
                    tag_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    shamt_q <= shamt_d;
                    op_q    <= op_d;
                    tag_q   <= tag_d;
                end
            end

            assign stage_valid[gi] = valid_q;
            assign stage_data[gi]  = data_q;
            assign stage_shamt[gi] = shamt_q;
            assign stage_op[gi]    = op_q;
            assign stage_tag[gi]   = tag_q;
        end
    endgenerate

    // Outputs come straight from the last stage's registers.
    assign bus.out_valid = stage_valid[SHAMT_W-1];
    assign bus.out_data  = stage_data[SHAMT_W-1];
    assign bus.out_tag   = stage_tag[SHAMT_W-1];
    assign bus.busy      = |stage_valid;
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The block SHALL have parameter NBits, default 32, giving the data width; it must be a power of two and at least 4.
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of the sideband tag carried with each operation (destination register id).
REQ-003 The block SHALL derive localparam SHAMT_W = log2(NBits); this is the shift-amount width and the pipeline depth.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 in_valid  input  1  an operation is presented on in_*.
REQ-007 in_ready  output  1  the block accepts in_* this cycle.
REQ-008 in_data  input  NBits  operand to shift.
REQ-009 in_shamt  input  SHAMT_W  shift amount, 0..NBits-1.
REQ-010 in_op  input  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 ROTL.
REQ-011 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-012 out_valid  output  1  a result is presented on out_*.
REQ-013 out_ready  input  1  downstream accepts out_* this cycle.
REQ-014 out_data  output  NBits  shifted result.
REQ-015 out_tag  output  TAG_W  tag of the operation that produced out_data.
REQ-016 busy  output  1  high when any pipeline stage holds a valid operation.

Function
REQ-017 The datapath SHALL consist of SHAMT_W registered stages; stage k (k = 0..SHAMT_W-1) conditionally shifts by 2^(SHAMT_W-1-k), so the MSB of the shift amount is applied first.
REQ-018 Each stage SHALL register: valid, data, remaining shamt bits, op, tag.
REQ-019 Per op, a stage with its shamt bit set SHALL apply:
- SLL: shift left, zero fill.
- SRL: shift right, zero fill.
- SRA: shift right, fill with the current data MSB.
- ROTL: rotate left, with bits shifted out of the MSB re-entering at the LSB.
REQ-020 A stage whose shamt bit is clear SHALL pass its data through unchanged.
REQ-021 Global advance enable SHALL be adv = !out_valid || out_ready.
REQ-022 All stages SHALL shift forward together only when adv = 1.
REQ-023 in_ready SHALL equal adv && !reset.
REQ-024 An operation SHALL be accepted when in_valid && in_ready.
REQ-025 When adv = 1 and in_valid = 0, stage 0 SHALL load valid = 0, inserting a bubble; bubbles are not compressed.
REQ-026 Latency SHALL be exactly SHAMT_W cycles from acceptance to out_valid when out_ready remains high.
REQ-027 Sustained throughput SHALL be one operation per cycle.
REQ-028 out_valid, out_data and out_tag SHALL be driven directly from the last stage's registers.
REQ-029 While out_valid && !out_ready, all stage registers SHALL hold and out_* SHALL remain stable.
REQ-030 Results SHALL leave in acceptance order; no operation is dropped or duplicated.
REQ-031 in_shamt = 0 SHALL return in_data unchanged for every op.
REQ-032 Simultaneous out handshake and in acceptance in the same cycle SHALL both complete.
REQ-033 busy SHALL be the OR of all stage valid bits.

Reset
REQ-034 While reset = 1 at a clock edge, every stage valid, data, shamt, op and tag register SHALL clear to 0.
REQ-035 After such a reset, out_valid = 0, out_data = 0, out_tag = 0 and busy = 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight operations; none emerge after reset deasserts.
REQ-037 in_ready SHALL be 0 while reset = 1.
REQ-038 The first operation SHALL be accepted on the first edge with reset = 0.

Verification (NBits = 32, SHAMT_W = 5, out_ready = 1 unless stated)
REQ-039 SLL: 0x00000001, shamt 31, tag 3 -> out_data 0x80000000 and out_tag 3, out_valid exactly 5 cycles after acceptance.
REQ-040 Right shifts:
- SRA 0x80000000, shamt 4 -> 0xF8000000.
- SRL same operands -> 0x08000000.
- SRA 0x7FFFFFFF, shamt 31 -> 0x00000000.
REQ-041 ROTL and zero shift:
- ROTL 0x80000001, shamt 1 -> 0x00000003.
- ROTL 0x12345678, shamt 16 -> 0x56781234.
- Any op with shamt 0 -> input unchanged.
REQ-042 Back-pressure: 3 back-to-back ops (tags 1, 2, 3), then out_ready low for 4 cycles after the first result appears -> out_data/out_tag frozen on tag 1, in_ready = 0 throughout; on release, tags 1, 2, 3 emerge on consecutive cycles with correct data.
REQ-043 Mid-flight reset: accept 2 ops, assert reset for 1 cycle at cycle 2 -> out_valid stays 0 for the following 10 cycles, busy = 0; a new op then completes with normal latency.
REQ-044 Random stream: 10,000 random ops with random in_valid/out_ready -> every result matches the reference model, in order, with no loss.
